// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search helper for the packet-locked arbiter.
package mux_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int unsigned RR_MAX_REQ = 64;
  localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

  // First valid index at or after ptr, wrapping at depth; returns ptr when nothing is valid.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [RR_MAX_REQ-1:0] valid,
                                          input int unsigned depth = RR_MAX_REQ);
    int unsigned idx;
    rr_next = ptr;
    for (int k = int'(RR_MAX_REQ) - 1; k >= 0; k--) begin
      if (k < int'(depth)) begin
        idx = ptr + unsigned'(k);
        if (idx >= depth) idx = idx - depth;
        if (valid[idx[RR_IDX_W-1:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotate-and-priority-encode: first valid requester at or after ptr.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int DEPTH  = 8,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [RR_MAX_REQ-1:0] valid_ext;

  always_comb begin
    valid_ext               = '0;
    valid_ext[DEPTH-1:0]    = valid;
    idx                     = SEL_W'(rr_next(32'(ptr), valid_ext, DEPTH));
    found                   = |valid;
  end

endmodule

// File: rtl/param_mux_sol.sv
// Word-wide DEPTH:1 multiplexer used as the arbiter datapath.
module param_mux_sol #(
  parameter int DEPTH     = 8,
  parameter int WORD_SIZE = 8,
  localparam int SEL_W    = $clog2(DEPTH)
) (
  input  logic [WORD_SIZE-1:0] i_input_signal [DEPTH],
  input  logic [SEL_W-1:0]     i_select,
  output logic [WORD_SIZE-1:0] o_out
);

  // Out-of-range selects (non power-of-two DEPTH) read as zero rather than X.
  always_comb begin
    o_out = '0;
    if (32'(i_select) < DEPTH) o_out = i_input_signal[i_select];
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one valid/ready channel among DEPTH requesters.
//   state    | meaning
//   ARB_IDLE | no grant held; arbitrate among valid requesters (one bubble cycle)
//   ARB_BUSY | o_select owns the channel until its last beat or MAX_BEATS beats
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WORD_SIZE = 8,
  parameter int MAX_BEATS = 16,
  localparam int SEL_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DEPTH-1:0]     i_req_valid,
  input  logic [DEPTH-1:0]     i_req_last,
  input  logic [WORD_SIZE-1:0] i_req_data [DEPTH],
  output logic [DEPTH-1:0]     o_req_ready,
  output logic                 o_out_valid,
  output logic                 o_out_last,
  output logic [WORD_SIZE-1:0] o_out_data,
  input  logic                 i_out_ready,
  output logic [SEL_W-1:0]     o_select,
  output logic                 o_busy
);

  arb_state_e       state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             beat_limit;
  logic             pkt_end;
  logic             xfer;
  logic [SEL_W-1:0] ptr_nxt;

  rr_pick #(.DEPTH(DEPTH)) u_pick (
    .valid (i_req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  param_mux_sol #(.DEPTH(DEPTH), .WORD_SIZE(WORD_SIZE)) u_mux (
    .i_input_signal (i_req_data),
    .i_select       (o_select),
    .o_out          (o_out_data)
  );

  assign o_busy      = (state == ARB_BUSY);
  assign beat_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign pkt_end     = i_req_last[o_select] | beat_limit;
  assign o_out_valid = o_busy & i_req_valid[o_select];
  assign o_out_last  = o_busy & pkt_end;
  assign o_req_ready = o_busy ? (DEPTH'(i_out_ready) << o_select) : '0;
  assign xfer        = o_out_valid & i_out_ready;
  assign ptr_nxt     = (o_select == SEL_W'(DEPTH - 1)) ? '0 : o_select + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ARB_IDLE;
      o_select <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            o_select <= pick_idx;
            state    <= ARB_BUSY;
            beat_cnt <= '0;
          end
        end
        ARB_BUSY: begin
          // A forced release sends the rest of the packet back through arbitration.
          if (xfer) begin
            if (pkt_end) begin
              state    <= ARB_IDLE;
              ptr      <= ptr_nxt;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed table-driven bench for mux_rr_arbiter (DEPTH=4, WORD_SIZE=8, MAX_BEATS=4).
module tb_mux_rr_arbiter;

  localparam int DEPTH = 4;
  localparam int WS    = 8;
  localparam int MB    = 4;

  logic             clk;
  logic             rst_n;
  logic [DEPTH-1:0] req_valid;
  logic [DEPTH-1:0] req_last;
  logic [WS-1:0]    req_data [DEPTH];
  logic [DEPTH-1:0] req_ready;
  logic             out_valid;
  logic             out_last;
  logic [WS-1:0]    out_data;
  logic             out_ready;
  logic [1:0]       sel;
  logic             busy;

  mux_rr_arbiter #(.DEPTH(DEPTH), .WORD_SIZE(WS), .MAX_BEATS(MB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_out_valid (out_valid),
    .o_out_last  (out_last),
    .o_out_data  (out_data),
    .i_out_ready (out_ready),
    .o_select    (sel),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ready;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_ov;
    logic       e_ol;
    logic [3:0] e_rr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic [5:0] src_seq [DEPTH];
  logic [5:0] snk_seq [DEPTH];
  logic       prev_stall;
  logic [WS-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic r,
                     input logic [1:0] s, input logic b, input logic ov,
                     input logic ol, input logic [3:0] rr);
    vec_t t;
    t.valid = v; t.last = l; t.ready = r;
    t.e_sel = s; t.e_busy = b; t.e_ov = ov; t.e_ol = ol; t.e_rr = rr;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    req_valid = v;
    req_last  = l;
    out_ready = r;
    for (int i = 0; i < DEPTH; i++) req_data[i] = WS'(i << 6) | WS'(src_seq[i]);
  endtask

  task automatic apply(input vec_t t, input int n);
    logic [1:0] tag;
    @(negedge clk);
    drive(t.valid, t.last, t.ready);
    #1;
    chk($sformatf("v%0d_select", n), 32'(sel), 32'(t.e_sel));
    chk($sformatf("v%0d_busy", n), 32'(busy), 32'(t.e_busy));
    chk($sformatf("v%0d_out_valid", n), 32'(out_valid), 32'(t.e_ov));
    chk($sformatf("v%0d_out_last", n), 32'(out_last), 32'(t.e_ol));
    chk($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(t.e_rr));
    chk($sformatf("v%0d_ready_onehot0", n), 32'($onehot0(req_ready)), 32'd1);
    if (out_valid) begin
      chk($sformatf("v%0d_data_mux", n), 32'(out_data), 32'(req_data[sel]));
      if (prev_stall) chk($sformatf("v%0d_stall_hold", n), 32'(out_data), 32'(prev_data));
      if (out_ready) begin
        tag = out_data[7:6];
        chk($sformatf("v%0d_beat_owner", n), 32'(tag), 32'(sel));
        chk($sformatf("v%0d_beat_order", n), 32'(out_data[5:0]), 32'(snk_seq[tag]));
        snk_seq[tag] = snk_seq[tag] + 6'd1;
      end
    end
    prev_stall = out_valid & ~out_ready;
    prev_data  = out_data;
    for (int i = 0; i < DEPTH; i++)
      if (req_ready[i] && req_valid[i]) src_seq[i] = src_seq[i] + 6'd1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin src_seq[i] = '0; snk_seq[i] = '0; end
    prev_stall = 1'b0;
    prev_data  = '0;
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);

    // fairness: single-beat packets from everyone, one bubble between grants
    add(4'b1111, 4'b1111, 1, 0, 0, 0, 0, 4'b0000);
    add(4'b1111, 4'b1111, 1, 0, 1, 1, 1, 4'b0001);
    add(4'b1111, 4'b1111, 1, 0, 0, 0, 0, 4'b0000);
    add(4'b1111, 4'b1111, 1, 1, 1, 1, 1, 4'b0010);
    add(4'b1111, 4'b1111, 1, 1, 0, 0, 0, 4'b0000);
    add(4'b1111, 4'b1111, 1, 2, 1, 1, 1, 4'b0100);
    add(4'b1111, 4'b1111, 1, 2, 0, 0, 0, 4'b0000);
    add(4'b1111, 4'b1111, 1, 3, 1, 1, 1, 4'b1000);
    add(4'b1111, 4'b1111, 1, 3, 0, 0, 0, 4'b0000);
    add(4'b1111, 4'b1111, 1, 0, 1, 1, 1, 4'b0001);
    // packet lock: req1 three beats while req2 waits
    add(4'b0110, 4'b0100, 1, 0, 0, 0, 0, 4'b0000);
    add(4'b0110, 4'b0100, 1, 1, 1, 1, 0, 4'b0010);
    add(4'b0110, 4'b0100, 1, 1, 1, 1, 0, 4'b0010);
    add(4'b0110, 4'b0110, 1, 1, 1, 1, 1, 4'b0010);
    add(4'b0100, 4'b0100, 1, 1, 0, 0, 0, 4'b0000);
    add(4'b0100, 4'b0100, 1, 2, 1, 1, 1, 4'b0100);
    // forced release: req0 six beats without last, req1 interleaves
    add(4'b0011, 4'b0010, 1, 2, 0, 0, 0, 4'b0000);
    add(4'b0011, 4'b0010, 1, 0, 1, 1, 0, 4'b0001);
    add(4'b0011, 4'b0010, 1, 0, 1, 1, 0, 4'b0001);
    add(4'b0011, 4'b0010, 1, 0, 1, 1, 0, 4'b0001);
    add(4'b0011, 4'b0010, 1, 0, 1, 1, 1, 4'b0001);
    add(4'b0011, 4'b0010, 1, 0, 0, 0, 0, 4'b0000);
    add(4'b0011, 4'b0010, 1, 1, 1, 1, 1, 4'b0010);
    add(4'b0001, 4'b0000, 1, 1, 0, 0, 0, 4'b0000);
    add(4'b0001, 4'b0000, 1, 0, 1, 1, 0, 4'b0001);
    add(4'b0001, 4'b0001, 1, 0, 1, 1, 1, 4'b0001);
    // backpressure on req3, ready toggling; beat limit counts transfers only
    add(4'b1000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(4'b1000, 4'b0000, 1, 3, 1, 1, 0, 4'b1000);
    add(4'b1000, 4'b0000, 0, 3, 1, 1, 0, 4'b0000);
    add(4'b1000, 4'b0000, 1, 3, 1, 1, 0, 4'b1000);
    add(4'b1000, 4'b0000, 0, 3, 1, 1, 0, 4'b0000);
    add(4'b1000, 4'b0000, 1, 3, 1, 1, 0, 4'b1000);
    add(4'b1000, 4'b0000, 0, 3, 1, 1, 1, 4'b0000);
    add(4'b1000, 4'b0000, 1, 3, 1, 1, 1, 4'b1000);
    // pointer wrapped to 0: req0 wins over req3
    add(4'b1001, 4'b1001, 1, 3, 0, 0, 0, 4'b0000);
    add(4'b1001, 4'b1001, 1, 0, 1, 1, 1, 4'b0001);
    add(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
    add(4'b0000, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);

    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_select", 32'(sel), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

    chk("beats_req0", 32'(snk_seq[0]), 32'd9);
    chk("beats_req1", 32'(snk_seq[1]), 32'd5);
    chk("beats_req2", 32'(snk_seq[2]), 32'd2);
    chk("beats_req3", 32'(snk_seq[3]), 32'd5);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("src_vs_sink_%0d", i), 32'(src_seq[i]), 32'(snk_seq[i]));

    // reset asserted mid-grant with ptr=1: outputs drop at once, ptr returns to 0
    @(negedge clk);
    drive(4'b0100, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_select", 32'(sel), 32'd2);
    #2;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_last", 32'(out_last), 32'd0);
    chk("async_rst_req_ready", 32'(req_ready), 32'd0);
    chk("async_rst_select", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b0);
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_grant_ptr0", 32'(sel), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
